pin_input_conditioner: RTL



---
 rtl/pin_cond_pkg.sv | 17 +
 rtl/pin_debounce_bit.sv | 104 ++++++++++
 rtl/pin_input_conditioner.sv | 119 +++++++++++
 3 files changed

// File: rtl/pin_cond_pkg.sv
// Shared types and constants for the pin input conditioner.
// Optional glitch statistics are enabled with PIN_COND_GLITCH_STATS_EN.
package pin_cond_pkg;

   typedef enum logic {
      ST_STABLE,
      ST_PENDING
   } deb_state_e;

   localparam logic [7:0] GLITCH_SAT = 8'hFF;

   // Counter must hold values 0..DEBOUNCE_CYCLES-1 plus headroom for the compare.
   function automatic int deb_cnt_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/pin_debounce_bit.sv
// Single-pin conditioner: two-flop synchroniser, debounce FSM with counter,
// registered clean value and one-cycle rise/fall pulses.
module pin_debounce_bit
   import pin_cond_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter logic        RESET_LEVEL     = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin_raw_i,
   input  logic tick_i,
   output logic pin_clean_o,
   output logic rise_o,
   output logic fall_o,
   output logic commit_o,
   output logic abort_o
);

   localparam int CW = deb_cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          clean_q;
   logic          rise_q;
   logic          fall_q;
   deb_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          commit;
   logic          abort;
   logic          differs;

   assign differs = (sync2_q != clean_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= RESET_LEVEL;
         sync2_q <= RESET_LEVEL;
         clean_q <= RESET_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         state_q <= ST_STABLE;
         cnt_q   <= '0;
      end else begin
         sync1_q <= pin_raw_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (commit) begin
            clean_q <= sync2_q;
         end
         rise_q  <= commit & sync2_q;
         fall_q  <= commit & ~sync2_q;
      end
   end

   // A glitch back to the clean level aborts immediately, independent of tick.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      abort   = 1'b0;
      case (state_q)
         ST_STABLE: begin
            cnt_d = '0;
            if (differs && tick_i) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  commit = 1'b1;
               end else begin
                  cnt_d   = CW'(1);
                  state_d = ST_PENDING;
               end
            end
         end
         ST_PENDING: begin
            if (!differs) begin
               cnt_d   = '0;
               state_d = ST_STABLE;
               abort   = 1'b1;
            end else if (tick_i) begin
               if (cnt_q == CNT_LAST) begin
                  commit  = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_STABLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_STABLE;
         end
      endcase
   end

   assign pin_clean_o = clean_q;
   assign rise_o      = rise_q;
   assign fall_o      = fall_q;
   assign commit_o    = commit;
   assign abort_o     = abort;

endmodule

// File: rtl/pin_input_conditioner.sv
// GPIO input conditioner feeding the core PINC input: per-bit sync/debounce,
// edge pulses, sticky maskable change flags. Glitch stats: PIN_COND_GLITCH_STATS_EN.
module pin_input_conditioner
   import pin_cond_pkg::*;
#(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned PRESCALE        = 1,
   parameter logic        RESET_LEVEL     = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] pin_raw,
   input  logic [WIDTH-1:0] irq_mask,
   input  logic [WIDTH-1:0] flag_clear,
`ifdef PIN_COND_GLITCH_STATS_EN
   input  logic             glitch_clear,
   output logic [7:0]       glitch_count,
`endif
   output logic [WIDTH-1:0] pin_clean,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic [WIDTH-1:0] change_flag,
   output logic             change_irq
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0]    presc_q, presc_d;
   logic             tick;
   logic [WIDTH-1:0] commit;
   logic [WIDTH-1:0] abort;
   logic [WIDTH-1:0] flag_q, flag_d;

   // With PRESCALE=1 the counter is pinned at 0 and tick is constantly high.
   assign tick    = (presc_q == PRE_LAST);
   assign presc_d = tick ? '0 : presc_q + PW'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         pin_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL)
         ) u_bit (
            .clk         (clk),
            .reset_n     (reset_n),
            .pin_raw_i   (pin_raw[gi]),
            .tick_i      (tick),
            .pin_clean_o (pin_clean[gi]),
            .rise_o      (rise_pulse[gi]),
            .fall_o      (fall_pulse[gi]),
            .commit_o    (commit[gi]),
            .abort_o     (abort[gi])
         );
      end
   endgenerate

   // Set has priority over a same-cycle clear; the mask only gates new sets.
   assign flag_d = (flag_q & ~flag_clear) | (commit & irq_mask);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flag_q <= '0;
      end else begin
         flag_q <= flag_d;
      end
   end

   assign change_flag = flag_q;
   assign change_irq  = |flag_q;

`ifdef PIN_COND_GLITCH_STATS_EN
   localparam int AW = $clog2(WIDTH + 1);
   localparam int SW = 8 + AW;

   logic [AW-1:0] abort_cnt;
   logic [SW-1:0] glitch_sum;
   logic [7:0]    glitch_q, glitch_d;

   always_comb begin
      abort_cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         abort_cnt = abort_cnt + AW'(abort[i]);
      end
      glitch_sum = SW'(glitch_q) + SW'(abort_cnt);
      if (glitch_clear) begin
         glitch_d = '0;
      end else if (glitch_sum > SW'(GLITCH_SAT)) begin
         glitch_d = GLITCH_SAT;
      end else begin
         glitch_d = glitch_sum[7:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         glitch_q <= '0;
      end else begin
         glitch_q <= glitch_d;
      end
   end

   assign glitch_count = glitch_q;
`else
   logic unused_abort;
   assign unused_abort = ^abort;
`endif

endmodule
